// File: rtl/reg16_pkg.sv
// Shared sizing constants and types for the 16-entry register file.
package reg16_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg16_read_port.sv
// One combinational read port: selects a single entry out of the register
// array by address. Instantiated once per read port of the register file.
module reg16_read_port #(
  parameter int DATA_W = reg16_pkg::DATA_W,
  parameter int ADDR_W = reg16_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  // Plain array index: zero latency, every address is a real entry.
  always_comb begin
    o_data = i_regs[i_addr];
  end

endmodule

// File: rtl/register16.sv
// Two-read, one-write register file with 2**ADDR_W entries.
// Reads are combinational with no write bypass; writes land on the rising
// clock edge; reset clears every entry asynchronously.
// Optional build macro REG16_ZERO_REG_EN turns entry 0 into a constant zero
// (writes to it are dropped and reads of it return 0).
module register16 #(
  parameter int DATA_W = reg16_pkg::DATA_W,
  parameter int ADDR_W = reg16_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rsAddr,
  input  logic [ADDR_W-1:0] rtAddr,
  input  logic [ADDR_W-1:0] rwAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              wEn,
  output logic [DATA_W-1:0] rs,
  output logic [DATA_W-1:0] rt
);

  import reg16_pkg::*;

  localparam int NUM_ENTRIES = 2 ** ADDR_W;

  // Storage keeps the plain name "data" so benches can reach it by hierarchy.
  logic [DATA_W-1:0] data [NUM_ENTRIES];

  logic              w_wrAllowed;
  logic [DATA_W-1:0] w_rsMux;
  logic [DATA_W-1:0] w_rtMux;

`ifdef REG16_ZERO_REG_EN
  // Entry 0 is hardwired, so a write aimed at it is simply dropped.
  assign w_wrAllowed = wEn && (rwAddr != '0);
`else
  assign w_wrAllowed = wEn;
`endif

  // Storage update: async clear wins over any write; otherwise one entry takes wData.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        data[i] <= '0;
      end
    end else if (w_wrAllowed) begin
      data[rwAddr] <= wData;
    end
  end

  reg16_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rsPort (
    .i_regs (data),
    .i_addr (rsAddr),
    .o_data (w_rsMux)
  );

  reg16_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rtPort (
    .i_regs (data),
    .i_addr (rtAddr),
    .o_data (w_rtMux)
  );

`ifdef REG16_ZERO_REG_EN
  // Force address 0 to read as zero even if the array was preloaded there.
  assign rs = (rsAddr == '0) ? '0 : w_rsMux;
  assign rt = (rtAddr == '0) ? '0 : w_rtMux;
`else
  assign rs = w_rsMux;
  assign rt = w_rtMux;
`endif

endmodule

// File: tb/tb_register16.sv
// Directed bench for register16: a small reference array tracks expected
// contents, expectations are queued when addresses are driven and popped
// when the outputs are sampled. Honours REG16_ZERO_REG_EN when defined.
module tb_register16;

  logic        clk;
  logic        rst;
  logic [3:0]  rsAddr;
  logic [3:0]  rtAddr;
  logic [3:0]  rwAddr;
  logic [15:0] wData;
  logic        wEn;
  logic [15:0] rs;
  logic [15:0] rt;

`ifdef REG16_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [15:0] model [16];
  logic [15:0] expQ [$];
  string       tagQ [$];
  int          passCount;
  int          checkCount;

  register16 dut (
    .clk    (clk),
    .rst    (rst),
    .rsAddr (rsAddr),
    .rtAddr (rtAddr),
    .rwAddr (rwAddr),
    .wData  (wData),
    .wEn    (wEn),
    .rs     (rs),
    .rt     (rt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record a write in the reference array, respecting the hardwired entry 0.
  task automatic modelWrite(input logic [3:0] addr, input logic [15:0] value);
    if (!(ZeroReg && addr == 4'd0)) begin
      model[addr] = value;
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 16; i++) begin
      model[i] = 16'h0000;
    end
  endtask

  // Drive both read addresses and queue what each port should show.
  task automatic applyStimulus(input logic [3:0] rsA, input logic [3:0] rtA, input string tag);
    rsAddr = rsA;
    rtAddr = rtA;
    expQ.push_back(model[rsA]);
    tagQ.push_back({tag, ".rs"});
    expQ.push_back(model[rtA]);
    tagQ.push_back({tag, ".rt"});
  endtask

  // Let the combinational path settle, then compare rs and rt against the queue.
  task automatic checkOutput();
    logic [15:0] expected;
    string       tag;
    logic [15:0] observed;
    #1;
    for (int p = 0; p < 2; p++) begin
      observed = (p == 0) ? rs : rt;
      if (expQ.size() == 0) begin
        checkCount++;
        $error("FAIL scoreboard_empty observed=%h", observed);
      end else begin
        expected = expQ.pop_front();
        tag      = tagQ.pop_front();
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  // One write cycle driven from the falling edge, released just after the rising edge.
  task automatic writeCycle(input logic [3:0] addr, input logic [15:0] value, input logic enable);
    @(negedge clk);
    rwAddr = addr;
    wData  = value;
    wEn    = enable;
    @(posedge clk);
    #1;
    wEn = 1'b0;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    modelClear();
    rst    = 1'b1;
    wEn    = 1'b0;
    rwAddr = 4'd0;
    wData  = 16'h0000;
    rsAddr = 4'd0;
    rtAddr = 4'd0;

    $display("[TB] reset state, before any clock edge");
    applyStimulus(4'd0, 4'd15, "reset");
    checkOutput();

    @(negedge clk);
    rst = 1'b0;

    $display("[TB] write 1 to address 0");
    writeCycle(4'd0, 16'h0001, 1'b1);
    modelWrite(4'd0, 16'h0001);
    applyStimulus(4'd0, 4'd1, "write0");
    checkOutput();

    $display("[TB] disabled write to address 3");
    writeCycle(4'd3, 16'hBEEF, 1'b0);
    applyStimulus(4'd3, 4'd3, "wrDisable");
    checkOutput();

    $display("[TB] read of the address being written, across the edge");
    @(negedge clk);
    rwAddr = 4'd5;
    wData  = 16'hA5A5;
    wEn    = 1'b1;
    applyStimulus(4'd5, 4'd5, "noBypassBefore");
    checkOutput();
    @(posedge clk);
    modelWrite(4'd5, 16'hA5A5);
    applyStimulus(4'd5, 4'd5, "noBypassAfter");
    checkOutput();
    wEn = 1'b0;

    $display("[TB] async reset mid-cycle, then write during reset");
    @(negedge clk);
    #2;
    rst = 1'b1;
    modelClear();
    applyStimulus(4'd5, 4'd0, "asyncClear");
    checkOutput();
    rwAddr = 4'd7;
    wData  = 16'h1234;
    wEn    = 1'b1;
    @(posedge clk);
    #1;
    wEn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd7, 4'd5, "wrDuringReset");
    checkOutput();

    $display("[TB] full sweep of all addresses");
    for (int i = 0; i < 16; i++) begin
      logic [15:0] value;
      value = 16'(i * 16'h1111);
      writeCycle(4'(i), value, 1'b1);
      modelWrite(4'(i), value);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'(i), 4'(15 - i), $sformatf("sweep%0d", i));
      checkOutput();
    end

    $display("[TB] async reset after sweep, then first write after release");
    @(negedge clk);
    #2;
    rst = 1'b1;
    modelClear();
    applyStimulus(4'd9, 4'd15, "sweepClear");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    writeCycle(4'd12, 16'h5A5A, 1'b1);
    modelWrite(4'd12, 16'h5A5A);
    applyStimulus(4'd12, 4'd11, "postReset");
    checkOutput();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
